// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - single-slave SPI master shift engine, all CPOL/CPHA modes
// Config and TX byte are shadowed at start so register writes mid-byte never disturb the wire.
module spi_master_engine #(
  parameter int D_WIDTH   = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 cont,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [D_WIDTH-1:0]   tx_data,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 ss_n,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   rx_data,
  output logic                 done
);

  localparam int EW = $clog2(2 * D_WIDTH);
  localparam logic [EW-1:0]        LAST_EDGE = EW'(2 * D_WIDTH - 1);
  localparam logic [EW-1:0]        EDGE_ONE  = EW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, XFER, LAST} state_t;

  state_t state, state_next;

  logic                 cpol_q;
  logic                 cpha_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [EW-1:0]        edge_cnt;
  logic [D_WIDTH-1:0]   tx_shift;
  logic [D_WIDTH-1:0]   rx_shift;

  logic load;
  logic tick;
  logic finish;
  logic leading;
  logic sample_edge;
  logic shift_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    tick       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          load       = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (div_cnt == div_q) begin
          tick = 1'b1;
          if (edge_cnt == LAST_EDGE) state_next = LAST;
        end
      end
      LAST: begin
        finish = 1'b1;
        if (cont && enable) begin
          load       = 1'b1;
          state_next = XFER;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // edge_cnt counts edges already made, so an even count means the next edge is leading
  assign leading     = ~edge_cnt[0];
  assign sample_edge = tick && (leading ^ cpha_q);
  assign shift_edge  = tick && (cpha_q ? leading : (!leading && edge_cnt != LAST_EDGE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      done <= finish;
      if (finish) rx_data <= rx_shift;

      if (load) begin
        cpol_q   <= cpol;
        cpha_q   <= cpha;
        div_q    <= clk_div;
        div_cnt  <= '0;
        edge_cnt <= '0;
        tx_shift <= tx_data;
        rx_shift <= '0;
        sclk     <= cpol;
        ss_n     <= 1'b0;
        busy     <= 1'b1;
        mosi     <= cpha ? 1'b0 : tx_data[D_WIDTH-1];
      end else if (state == IDLE) begin
        sclk <= cpol;
        mosi <= 1'b0;
        ss_n <= 1'b1;
        busy <= 1'b0;
      end else if (state == LAST) begin
        sclk <= cpol_q;
        mosi <= 1'b0;
        ss_n <= 1'b1;
        busy <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
        if (tick) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + EDGE_ONE;
        end
        if (sample_edge) rx_shift <= {rx_shift[D_WIDTH-2:0], miso};
        // cpha=1 drives the current MSB; cpha=0 already shows it and advances to the next bit
        if (shift_edge) begin
          mosi     <= cpha_q ? tx_shift[D_WIDTH-1] : tx_shift[D_WIDTH-2];
          tx_shift <= tx_shift << 1;
        end
      end
    end
  end

endmodule
